sad_min_select: RTL and testbench

Downstream consumer of the 4-stage SAD adder tree. It takes one 14-bit SAD per search candidate and tracks the minimum over a full (2R+1)×(2R+1) search window in raster order. At the end of the window it presents the winning motion vector and its SAD on a valid/ready output. This is the block that turns the per-candidate SAD stream into one motion-vector result per macroblock.

---
 rtl/sad_min_select_if.sv | 24 ++
 rtl/sad_min_select.sv | 139 +++++++++++++
 tb/tb_sad_min_select.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sad_min_select_if.sv
// Handshake bundle between the SAD adder-tree controller, the minimum selector
// and the motion-vector consumer.
interface sad_min_select_if;
  logic        start;
  logic        sad_valid;
  logic [13:0] sad;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] best_sad;
  logic [7:0]  best_mvx;
  logic [7:0]  best_mvy;
  logic        busy;
  logic        overrun;

  modport master (
    output start, sad_valid, sad, out_ready,
    input  out_valid, best_sad, best_mvx, best_mvy, busy, overrun
  );

  modport slave (
    input  start, sad_valid, sad, out_ready,
    output out_valid, best_sad, best_mvx, best_mvy, busy, overrun
  );
endinterface

// File: rtl/sad_min_select.sv
// Tracks the minimum SAD over a (2R+1)x(2R+1) raster search window and presents
// the winning motion vector and SAD on a valid/ready output.
module sad_min_select #(
  parameter int unsigned R = 4
) (
  input  logic              clk,
  input  logic              rst,
  sad_min_select_if.slave   bus
);

  localparam int unsigned CW = $clog2(2 * R + 1);
  localparam logic [CW-1:0] LAST = CW'(2 * R);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_x_q, cnt_x_d;
  logic [CW-1:0] cnt_y_q, cnt_y_d;
  logic          first_q, first_d;
  logic [13:0]   best_sad_q, best_sad_d;
  logic [7:0]    best_mvx_q, best_mvx_d;
  logic [7:0]    best_mvy_q, best_mvy_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;

  // Offsets are formed modulo 2^9; the low byte is the two's-complement -R..+R.
  logic [8:0] dx9, dy9;
  assign dx9 = 9'(cnt_x_q) - 9'(R);
  assign dy9 = 9'(cnt_y_q) - 9'(R);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_x_q     <= '0;
      cnt_y_q     <= '0;
      first_q     <= 1'b0;
      best_sad_q  <= '0;
      best_mvx_q  <= '0;
      best_mvy_q  <= '0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_x_q     <= cnt_x_d;
      cnt_y_q     <= cnt_y_d;
      first_q     <= first_d;
      best_sad_q  <= best_sad_d;
      best_mvx_q  <= best_mvx_d;
      best_mvy_q  <= best_mvy_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_x_d    = cnt_x_q;
    cnt_y_d    = cnt_y_q;
    first_d    = first_q;
    best_sad_d = best_sad_q;
    best_mvx_d = best_mvx_q;
    best_mvy_d = best_mvy_q;
    overrun_d  = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          cnt_x_d = '0;
          cnt_y_d = '0;
          first_d = 1'b1;
        end
      end

      SCAN: begin
        // A restart takes priority and drops any sample in the same cycle.
        if (bus.start) begin
          cnt_x_d = '0;
          cnt_y_d = '0;
          first_d = 1'b1;
        end else if (bus.sad_valid) begin
          if (first_q || (bus.sad < best_sad_q)) begin
            best_sad_d = bus.sad;
            best_mvx_d = dx9[7:0];
            best_mvy_d = dy9[7:0];
          end
          first_d = 1'b0;
          if (cnt_x_q == LAST) begin
            cnt_x_d = '0;
            if (cnt_y_q == LAST) begin
              cnt_y_d = '0;
              state_d = DONE;
            end else begin
              cnt_y_d = cnt_y_q + 1'b1;
            end
          end else begin
            cnt_x_d = cnt_x_q + 1'b1;
          end
        end
      end

      DONE: begin
        if (bus.sad_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.out_ready) begin
          if (bus.start) begin
            state_d = SCAN;
            cnt_x_d = '0;
            cnt_y_d = '0;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d      = (state_d == SCAN);
    out_valid_d = (state_d == DONE);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.best_mvx  = best_mvx_q;
  assign bus.best_mvy  = best_mvy_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Directed bench for sad_min_select at R=4 (81 candidates per window).
module tb_sad_min_select;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_errors;
  logic [13:0] vec [0:80];

  sad_min_select_if sif();

  sad_min_select #(.R(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int unsigned n, input int unsigned gap);
    for (int unsigned i = 0; i < n; i++) begin
      sif.sad_valid = 1'b1;
      sif.sad       = vec[i];
      tick();
      sif.sad_valid = 1'b0;
      if (i + 1 < n) repeat (gap) tick();
    end
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    check("busy_after_start", 32'(sif.busy), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [13:0] s,
                              input logic [7:0] mx, input logic [7:0] my);
    check({tag, "_valid"}, 32'(sif.out_valid), 32'd1);
    check({tag, "_busy"},  32'(sif.busy),      32'd0);
    check({tag, "_sad"},   32'(sif.best_sad),  32'(s));
    check({tag, "_mvx"},   32'(sif.best_mvx),  32'(mx));
    check({tag, "_mvy"},   32'(sif.best_mvy),  32'(my));
  endtask

  task automatic accept();
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    check("accept_drop", 32'(sif.out_valid), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    sif.start     = 1'b0;
    sif.sad_valid = 1'b0;
    sif.sad       = '0;
    sif.out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of a scan
    for (int i = 0; i < 81; i++) vec[i] = 14'(50 + i);
    pulse_start();
    feed(10, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid",   32'(sif.out_valid), 32'd0);
    check("rst_busy",    32'(sif.busy),      32'd0);
    check("rst_overrun", 32'(sif.overrun),   32'd0);
    check("rst_sad",     32'(sif.best_sad),  32'd0);
    check("rst_mvx",     32'(sif.best_mvx),  32'd0);
    check("rst_mvy",     32'(sif.best_mvy),  32'd0);
    feed(3, 1);
    tick();
    check("nostart_valid",   32'(sif.out_valid), 32'd0);
    check("nostart_overrun", 32'(sif.overrun),   32'd0);
    check("nostart_busy",    32'(sif.busy),      32'd0);

    // Decreasing sweep: last candidate is the minimum
    for (int i = 0; i < 81; i++) vec[i] = 14'(16320 - i);
    pulse_start();
    feed(80, 0);
    check("sweep_pre_last", 32'(sif.out_valid), 32'd0);
    sif.sad_valid = 1'b1;
    sif.sad       = vec[80];
    tick();
    sif.sad_valid = 1'b0;
    check_result("sweep", 14'd16240, 8'h04, 8'h04);
    accept();

    // Tie: earliest in raster order wins (k=10 -> (-3,-3))
    for (int i = 0; i < 81; i++) vec[i] = 14'd500;
    vec[10] = 14'd100;
    vec[50] = 14'd100;
    pulse_start();
    feed(81, 0);
    check_result("tie", 14'd100, 8'hFD, 8'hFD);
    accept();

    // Zero at the window centre
    for (int i = 0; i < 81; i++) vec[i] = 14'd500;
    vec[40] = 14'd0;
    pulse_start();
    feed(81, 0);
    check_result("centre", 14'd0, 8'h00, 8'h00);
    accept();

    // Gaps of two idle cycles, then backpressure and an overrun sample
    for (int i = 0; i < 81; i++) vec[i] = 14'd1000;
    vec[60] = 14'd5;
    pulse_start();
    feed(81, 2);
    check_result("gap", 14'd5, 8'h02, 8'h02);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        sif.sad_valid = 1'b1;
        sif.sad       = 14'd0;
      end
      tick();
      sif.sad_valid = 1'b0;
      check("hold_valid", 32'(sif.out_valid), 32'd1);
      check("hold_sad",   32'(sif.best_sad),  32'd5);
      check("hold_mvx",   32'(sif.best_mvx),  32'h02);
      check("hold_mvy",   32'(sif.best_mvy),  32'h02);
      check("overrun",    32'(sif.overrun),   (i >= 2) ? 32'd1 : 32'd0);
    end
    accept();

    // Restart after 30 low-SAD samples; restart-cycle sample is discarded
    for (int i = 0; i < 81; i++) vec[i] = 14'd1;
    pulse_start();
    feed(30, 0);
    sif.start     = 1'b1;
    sif.sad_valid = 1'b1;
    sif.sad       = 14'd0;
    tick();
    sif.start     = 1'b0;
    sif.sad_valid = 1'b0;
    check("restart_busy", 32'(sif.busy), 32'd1);
    for (int i = 0; i < 81; i++) vec[i] = 14'd200;
    vec[0] = 14'd7;
    feed(81, 0);
    check_result("restart", 14'd7, 8'hFC, 8'hFC);

    // Accept and start together: next scan begins without an idle cycle
    sif.out_ready = 1'b1;
    sif.start     = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    sif.start     = 1'b0;
    check("chain_valid", 32'(sif.out_valid), 32'd0);
    check("chain_busy",  32'(sif.busy),      32'd1);
    for (int i = 0; i < 81; i++) vec[i] = 14'(16320 - i);
    feed(81, 0);
    check_result("chain", 14'd16240, 8'h04, 8'h04);
    accept();
    check("overrun_sticky", 32'(sif.overrun), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
